// File: rtl/program_loader.sv
// Framed byte-stream loader: writes LEN-prefixed program bytes into memory,
// verifies the trailing checksum and releases the processor via cpu_run.
module program_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_req,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_run,
  output logic       busy,
  output logic       error,
  output logic [8:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [8:0]    len;
  logic [7:0]    csum;
  logic [7:0]    csum_final;
  logic          xfer;
  logic          start;
  logic          last_data;
  logic          tmo;

  always_comb begin
    xfer       = in_valid && in_ready;
    start      = load_req && (state == S_IDLE || state == S_RUN || state == S_ERR);
    last_data  = (byte_count + 9'd1) == len;
    csum_final = csum + in_data;
    // Timeout fires on the idle cycle that would bring the counter to TIMEOUT.
    tmo        = busy && !in_valid && (tcnt == TLIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RUN, S_ERR: if (load_req) state_nxt = S_LEN;
      S_LEN: begin
        if (tmo)       state_nxt = S_ERR;
        else if (xfer) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (tmo)                    state_nxt = S_ERR;
        else if (xfer && last_data) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (tmo)       state_nxt = S_ERR;
        else if (xfer) state_nxt = (csum_final == 8'h00) ? S_RUN : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    in_ready = busy;
    cpu_run  = (state == S_RUN);
    error    = (state == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      byte_count <= '0;
      csum       <= '0;
      tcnt       <= '0;
      len        <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        byte_count <= '0;
        csum       <= '0;
        tcnt       <= '0;
      end else if (busy) begin
        tcnt <= xfer ? '0 : tcnt + 1'b1;
        if (xfer && state == S_LEN)
          len <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
        if (xfer && state == S_DATA) begin
          mem_we     <= 1'b1;
          mem_addr   <= BASE_ADDR + byte_count[7:0];
          mem_wdata  <= in_data;
          byte_count <= byte_count + 9'd1;
          csum       <= csum_final;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level model.
module tb_program_loader;

  localparam logic [7:0]  BASE = 8'h80;
  localparam int unsigned TMO  = 8;

  logic       clk;
  logic       rst_n;
  logic       load_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       error;
  logic [8:0] byte_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  dq[$];
  logic [15:0] mon_e;

  program_loader #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .error(error),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", mem_addr, mon_e[15:8]);
        check("wdata", mem_wdata, mon_e[7:0]);
      end
      check("run_during_we", cpu_run, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  // All drive tasks start and end at a negedge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gmin,
                           input int unsigned gmax, input bit noise);
    int unsigned gap;
    gap = $urandom_range(gmax, gmin);
    for (int unsigned g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      load_req = noise && ($urandom_range(0, 3) == 0);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    load_req = noise && ($urandom_range(0, 3) == 0);
    check("in_ready", in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic start_load();
    load_req = 1'b1;
    in_valid = 1'($urandom);
    @(posedge clk); @(negedge clk);
    load_req = 1'b0;
    in_valid = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_ready", in_ready, 1'b1);
    check("start_run", cpu_run, 1'b0);
    check("start_err", error, 1'b0);
    check("start_count", byte_count, 9'd0);
  endtask

  task automatic run_frame(input logic [7:0] len_b, input logic [7:0] cs,
                           input int unsigned gmin, input int unsigned gmax,
                           input bit noise);
    int unsigned n;
    logic [7:0]  sum;
    logic [7:0]  a;
    bit          ok;
    n   = (len_b == 8'h00) ? 256 : int'(len_b);
    sum = cs;
    for (int unsigned i = 0; i < n; i++) begin
      sum = sum + dq[i];
      a   = BASE + 8'(i);
      exp_q.push_back({a, dq[i]});
    end
    ok = (sum == 8'h00);
    start_load();
    send_byte(len_b, gmin, gmax, noise);
    for (int unsigned i = 0; i < n; i++) send_byte(dq[i], gmin, gmax, noise);
    check("run_before_csum", cpu_run, 1'b0);
    send_byte(cs, gmin, gmax, noise);
    in_valid = 1'b0;
    load_req = 1'b0;
    check("frame_run", cpu_run, ok);
    check("frame_err", error, !ok);
    check("frame_busy", busy, 1'b0);
    check("frame_ready", in_ready, 1'b0);
    check("frame_count", byte_count, n);
    check("frame_pending", exp_q.size(), 0);
    a = BASE + 8'(n - 1);
    check("hold_addr", mem_addr, a);
    check("hold_wdata", mem_wdata, dq[n-1]);
  endtask

  task automatic good_small();
    dq = {8'h11, 8'h22, 8'h33};
  endtask

  initial begin
    logic [7:0] lb, cs, s;
    rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_run", cpu_run, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", error, 1'b0);
    check("rst_count", byte_count, 9'd0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    in_valid = 1'b0;
    check("idle_busy", busy, 1'b0);

    good_small(); run_frame(8'h03, 8'h9A, 0, 0, 0);
    good_small(); run_frame(8'h03, 8'h9B, 0, 0, 0);
    good_small(); run_frame(8'h03, 8'h9A, 0, 0, 0);

    dq.delete();
    for (int unsigned i = 0; i < 256; i++) dq.push_back(8'(i));
    run_frame(8'h00, 8'h80, 0, 0, 0);

    // Alternating valid with stray load_req pulses, then maximal legal gaps.
    good_small(); run_frame(8'h03, 8'h9A, 1, 1, 1);
    good_small(); run_frame(8'h03, 8'h9A, TMO - 1, TMO - 1, 0);

    for (int unsigned f = 0; f < 12; f++) begin
      lb = 8'($urandom_range(1, 24));
      dq.delete();
      s = '0;
      for (int unsigned i = 0; i < int'(lb); i++) begin
        dq.push_back(8'($urandom));
        s = s + dq[i];
      end
      cs = 8'h00 - s;
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      run_frame(lb, cs, 0, 3, 1);
    end

    // Timeout after LEN=4 and two data bytes.
    start_load();
    send_byte(8'h04, 0, 0, 0);
    for (int unsigned i = 0; i < 2; i++) begin
      s = 8'($urandom);
      lb = BASE + 8'(i);
      exp_q.push_back({lb, s});
      send_byte(s, 0, 0, 0);
    end
    for (int unsigned k = 1; k <= TMO; k++) begin
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      if (k == TMO - 1) check("tmo_not_yet", busy, 1'b1);
    end
    check("tmo_err", error, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_ready", in_ready, 1'b0);
    check("tmo_count", byte_count, 9'd2);
    check("tmo_run", cpu_run, 1'b0);

    // Asynchronous reset between edges during DATA.
    good_small(); run_frame(8'h03, 8'h9A, 0, 0, 0);
    start_load();
    send_byte(8'h0A, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      s = 8'($urandom);
      lb = BASE + 8'(i);
      exp_q.push_back({lb, s});
      send_byte(s, 0, 0, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 1'b0);
    check("arst_we", mem_we, 1'b0);
    check("arst_addr", mem_addr, BASE);
    check("arst_wdata", mem_wdata, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_count", byte_count, 9'd0);
    check("arst_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (4) begin in_data = 8'($urandom); @(posedge clk); @(negedge clk); end
    in_valid = 1'b0;
    check("arst_idle_busy", busy, 1'b0);
    check("arst_idle_ready", in_ready, 1'b0);
    check("arst_idle_run", cpu_run, 1'b0);
    good_small(); run_frame(8'h03, 8'h9A, 0, 2, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the 8-bit processor's unified memory.
- Accepts a framed byte stream over a valid/ready handshake and writes the program bytes into memory through the memory write port.
- Verifies an 8-bit checksum, then releases the processor via cpu_run. The processor's fetch loop stays gated off until the load succeeds.

Parameters:
- BASE_ADDR, 8'h00, first memory address written; later bytes use BASE_ADDR+i mod 256.
- TIMEOUT, 1024, idle cycles allowed with in_valid low while a frame is in progress before aborting; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- load_req  input  1  single-cycle request to start a new load.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept in_data this cycle.
- mem_we  output  1  memory write enable, one-cycle pulse per program byte.
- mem_addr  output  8  memory write address.
- mem_wdata  output  8  memory write data.
- cpu_run  output  1  high means the processor may fetch and execute.
- busy  output  1  high while a frame is in progress.
- error  output  1  high after a failed load until the next load_req or reset.
- byte_count  output  9  program bytes written in the current or last frame (0..256).

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_run=0, busy=0, error=0, byte_count=0, checksum accumulator=0, timeout counter=0.
- Reset asserted mid-frame aborts immediately. Memory bytes already written are not rolled back.
- A byte transfer occurs on a posedge with in_valid=1 and in_ready=1.
- Frame format:
  - LEN byte: N, where 0 encodes 256.
  - N data bytes.
  - One CSUM byte. A frame is valid when (sum of data bytes + CSUM) mod 256 == 0. LEN is not included in the sum.
- States:
  - IDLE: in_ready=0. load_req goes to LEN; clear byte_count, checksum, error and timeout counter; busy=1.
  - LEN: in_ready=1. On transfer, latch N (9-bit, 0 becomes 256) and go to DATA.
  - DATA: in_ready=1. On each transfer, in the following cycle drive mem_we=1, mem_addr=BASE_ADDR+byte_count (8-bit wrap) and mem_wdata=byte. byte_count increments, checksum += byte. Go to CSUM after the Nth byte. Write latency is exactly 1 cycle after the transfer, so back-to-back transfers give back-to-back write pulses.
  - CSUM: in_ready=1. On transfer, if (checksum+byte) mod 256 == 0 go to RUN; otherwise go to ERR.
  - RUN: cpu_run=1, busy=0, in_ready=0.
  - ERR: error=1, cpu_run=0, busy=0, in_ready=0.
- load_req handling:
  - Ignored while busy=1.
  - In RUN or ERR, load_req drops cpu_run in the next cycle and restarts at LEN.
- Timeout:
  - In LEN, DATA or CSUM, the timeout counter increments each cycle with in_valid=0 and clears on any transfer.
  - On reaching TIMEOUT, go to ERR. byte_count holds the bytes written so far.
- cpu_run is never high while mem_we can pulse. The last mem_we pulse occurs no later than the cycle in which cpu_run first rises.
- Outside the DATA write pulse, mem_addr and mem_wdata hold their last values and mem_we=0.

Test Plan:
- Valid 3-byte frame: load_req, then stream 03, 11, 22, 33, 9A -> writes 11@00, 22@01, 33@02; byte_count=3; cpu_run=1 one cycle after the CSUM transfer; error=0.
- Bad checksum: same frame with CSUM 9B -> three writes still occur, then state ERR with error=1 and cpu_run=0. A following load_req with the good frame clears error and sets cpu_run=1.
- LEN=00 with BASE_ADDR=8'h80: 256 bytes of value i with CSUM 80 -> 256 writes at addresses 80..FF then 00..7F; byte_count=256; cpu_run=1.
- Backpressure and ignored request: in_valid toggling every other cycle, plus a load_req pulse mid-frame -> request ignored; one write per accepted byte; the frame completes normally.
- Timeout: TIMEOUT=8; after LEN=04 and two data bytes, hold in_valid=0 for 8 cycles -> ERR with byte_count=2 and in_ready=0.
- Async reset mid-DATA: drive rst_n low between edges -> all outputs go to reset values without waiting for a clock edge, and the loader stays in IDLE until load_req.
